scope_wave_display: RTL and testbench
=====================================

# scope_wave_display

Parametrised oscilloscope-style display generator for the HDMI video path. It sits between the video timing driver and the HDMI encoder, like the existing colour-bar and grid generators. From the incoming pixel coordinates it draws a bordered plot window with a dotted grid and centre axes. Over that background it draws up to four waveform traces, read from a double-buffered sample memory that a capture block fills and commits once per frame.

## Interface
Parameters:
- H_DISP, 1280, active pixels per line
- V_DISP, 720, active lines per frame
- X0 / X1, 139 / 1140, left/right border columns (inclusive)
- Y0 / Y1, 48 / 624, top/bottom border rows (inclusive)
- GRID_X / GRID_Y, 64 / 48, grid pitch in pixels/lines, measured from X0 / Y0
- N_CH, 2, trace channels (1..4)
- SAMPLE_W, 9, sample width (unsigned)
- DEPTH, X1-X0-1 (1000), samples per channel = plot columns
- AW, 10, sample address width, clog2(DEPTH)

Ports:
- pixel_clk  in  1  pixel clock; the only clock
- sys_rst  in  1  synchronous reset, active high
- pixel_xpos  in  11  current pixel column; increments by 1 per clock within a line
- pixel_ypos  in  11  current line
- ch_en  in  N_CH  per-channel trace enable
- wr_en  in  1  sample write strobe (back bank)
- wr_ch  in  2  channel index of write
- wr_addr  in  AW  column index 0..DEPTH-1
- wr_data  in  SAMPLE_W  sample value
- wr_commit  in  1  one-cycle pulse: back bank complete, request swap
- buf_busy  out  1  swap pending; writes are dropped while high
- pixel_data  out  24  RGB888 pixel

## Operation
- Regions, evaluated on the current coordinates:
  - window: X0≤x≤X1 and Y0≤y≤Y1.
  - border: x∈{X0,X1} or y∈{Y0,Y1}.
  - axis: x==(X0+X1+1)/2 or y==(Y0+Y1)/2.
- Grid uses phase counters, not dividers:
  - gx counts 0..GRID_X-1; it resets at x==X0 and wraps.
  - gy counts 0..GRID_Y-1; it resets at line Y0 and advances at x==X0 of each later line.
  - Grid pixel: (gx==0 and y[0]) or (gy==0 and x[0]).
- Trace column c = x-X0-1 for X0<x<X1. Row of sample s is r(s)=Y0+1+(2^SAMPLE_W-1-s).
  - Channel k lights pixel (x,y) when ch_en[k] and min(r(s_c),r(s_prev)) ≤ y ≤ max(r(s_c),r(s_prev)).
  - s_prev is channel k's sample at c-1; at c==0, s_prev = s_c. This fills vertical steps between adjacent columns.
  - Samples with r(s)>Y1-1 are clipped; only rows inside the window are drawn.
- Colour priority, highest first:
  - ch0 YELLOW, ch1 CYAN, ch2 MAGENTA, ch3 RED
  - border/axis GREEN (00_FF_00)
  - grid DKGREEN (00_7F_00)
  - otherwise BLACK; outside the window always BLACK.
- Buffering: two banks per channel.
  - The front bank is displayed; wr_en writes go to the back bank.
  - wr_commit sets pending (buf_busy=1).
  - At frame start (x==0 and y==0), if pending is set: swap front/back and clear pending.
  - wr_commit coincident with frame start swaps at that same frame start.
  - wr_en while pending, or with wr_ch≥N_CH or wr_addr≥DEPTH, is ignored.
- Reset: front=bank 0, pending=0, buf_busy=0, pixel_data=0, counters cleared. Memory contents are not reset. Reset mid-frame resumes with correct output from the next frame start.

## Timing
- Fixed 2-cycle latency from pixel_xpos/pixel_ypos to pixel_data; the driver compensates.
- Stage 0: compute region flags and column address; issue RAM reads for all channels.
- Stage 1: RAM data valid; s_prev register holds the previous cycle's read; region flags delayed one cycle.
- Stage 2: compare, apply priority, register pixel_data.
- The bank select used for reads changes only at frame start. No frame ever mixes banks.
- buf_busy rises the cycle after wr_commit and falls the cycle after the swapping frame-start cycle.

## Structure
- Package scope_pkg holds:
  - the colour constants (BLACK, GREEN, DKGREEN, channel colour array)
  - the r(s) mapping function.
- Sub-module scope_sample_ram: simple dual-port, one write and one registered read port.
  - Depth 2·DEPTH per channel, with the bank as address MSB.
  - One instance per channel via generate.

## Test plan
- Empty memory after reset, ch_en=0, full frame -> border/axis pixels 00FF00, grid pixels 007F00, all others 000000, outside window 000000. pixel_data lags coordinates by exactly 2 clocks.
- ch0 constant 256 in all columns, commit, ch_en=1 -> one yellow row at y=Y0+256 across x=140..1139; no pixels before the next frame start.
- ch0 step 0→511 at column 500 -> yellow vertical fill from y=Y0+1 to Y0+512 at x=640. The yellow overrides the axis green.
- ch0 and ch1 both 100 -> overlapping pixels yellow (ch0 priority); ch_en=2'b10 -> cyan.
- wr_commit mid-frame -> buf_busy=1; writes during busy leave the back bank unchanged. Swap happens at the next (0,0), then buf_busy=0. Commit at exactly (0,0) swaps immediately.
- sys_rst asserted mid-line -> next clock pixel_data=0 and buf_busy=0. Bank 0 is displayed afterwards.

Source files
------------

// File: rtl/scope_pkg.sv
// rtl/scope_pkg.sv - colour constants and sample-to-row mapping for the scope display
package scope_pkg;

    localparam logic [23:0] BLACK   = 24'h000000;
    localparam logic [23:0] GREEN   = 24'h00FF00;
    localparam logic [23:0] DKGREEN = 24'h007F00;

    // Trace colours in priority order: ch0 wins over ch1 and so on.
    localparam logic [23:0] CH_COLOR [4] = '{24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'hFF0000};

    // Largest sample maps to the first row inside the top border.
    function automatic logic [11:0] sample_row(input logic [11:0] y0, input logic [11:0] s,
                                               input int sample_w);
        logic [11:0] full;
        full = 12'((1 << sample_w) - 1);
        return y0 + 12'd1 + (full - s);
    endfunction

endpackage

// File: rtl/scope_sample_ram.sv
// rtl/scope_sample_ram.sv - two-bank sample store, one write port and one registered read port
module scope_sample_ram #(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 1000,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW:0]       wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW:0]       rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // Address MSB selects the bank.
    logic [DATA_W-1:0] mem [2][DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[AW]][wr_addr[AW-1:0]] <= wr_data;
        end
        rd_data <= mem[rd_addr[AW]][rd_addr[AW-1:0]];
    end

endmodule

// File: rtl/scope_wave_display.sv
// rtl/scope_wave_display.sv - plot window with grid, axes and up to four double-buffered traces
module scope_wave_display
    import scope_pkg::*;
#(
    parameter int H_DISP   = 1280,
    parameter int V_DISP   = 720,
    parameter int X0       = 139,
    parameter int X1       = 1140,
    parameter int Y0       = 48,
    parameter int Y1       = 624,
    parameter int GRID_X   = 64,
    parameter int GRID_Y   = 48,
    parameter int N_CH     = 2,
    parameter int SAMPLE_W = 9,
    parameter int DEPTH    = X1 - X0 - 1,
    parameter int AW       = 10
) (
    input  logic                pixel_clk,
    input  logic                sys_rst,
    input  logic [10:0]         pixel_xpos,
    input  logic [10:0]         pixel_ypos,
    input  logic [N_CH-1:0]     ch_en,
    input  logic                wr_en,
    input  logic [1:0]          wr_ch,
    input  logic [AW-1:0]       wr_addr,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic                wr_commit,
    output logic                buf_busy,
    output logic [23:0]         pixel_data
);

    localparam logic [10:0] X0_C = 11'(X0);
    localparam logic [10:0] X1_C = 11'(X1);
    localparam logic [10:0] Y0_C = 11'(Y0);
    localparam logic [10:0] Y1_C = 11'(Y1);
    localparam logic [10:0] XA_C = 11'((X0 + X1 + 1) / 2);
    localparam logic [10:0] YA_C = 11'((Y0 + Y1) / 2);
    localparam logic [10:0] HD_C = 11'(H_DISP);
    localparam logic [10:0] VD_C = 11'(V_DISP);
    localparam int GXW = $clog2(GRID_X);
    localparam int GYW = $clog2(GRID_Y);
    localparam logic [GXW-1:0] GX_LAST = GXW'(GRID_X - 1);
    localparam logic [GYW-1:0] GY_LAST = GYW'(GRID_Y - 1);

    logic [10:0] x, y;
    assign x = pixel_xpos;
    assign y = pixel_ypos;

    logic           front, pending, frame_start, wr_ok;
    logic [GXW-1:0] gx_q, gx;
    logic [GYW-1:0] gy_q, gy;
    logic           in_win, on_line, on_grid, trace_col, first_col;
    logic [AW-1:0]  col;
    logic           s1_win, s1_line, s1_grid, s1_trace, s1_first;
    logic [10:0]    s1_y;
    logic [N_CH-1:0] hit;
    logic [23:0]    pix;

    assign frame_start = (x == 11'd0) && (y == 11'd0);
    assign buf_busy    = pending;
    assign wr_ok       = wr_en && !pending && ({1'b0, wr_ch} < 3'(N_CH))
                         && ({1'b0, wr_addr} < (AW + 1)'(DEPTH));

    // Grid phases restart at the window's left edge / top line instead of dividing x and y.
    always_comb begin
        gx = gx_q;
        gy = gy_q;
        if (x == X0_C) begin
            gx = '0;
            if (y == Y0_C)           gy = '0;
            else if (gy_q == GY_LAST) gy = '0;
            else                     gy = gy_q + 1'b1;
        end
    end

    assign in_win    = (x >= X0_C) && (x <= X1_C) && (y >= Y0_C) && (y <= Y1_C)
                       && (x < HD_C) && (y < VD_C);
    assign on_line   = (x == X0_C) || (x == X1_C) || (y == Y0_C) || (y == Y1_C)
                       || (x == XA_C) || (y == YA_C);
    assign on_grid   = ((gx == '0) && y[0]) || ((gy == '0) && x[0]);
    assign trace_col = (x > X0_C) && (x < X1_C) && (y > Y0_C) && (y < Y1_C);
    assign first_col = (x == X0_C + 11'd1);
    assign col       = trace_col ? AW'(x - X0_C - 11'd1) : '0;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [SAMPLE_W-1:0] rd_data, prev_q, sp;
        logic [11:0]         rc, rp, lo, hi;

        scope_sample_ram #(.DATA_W(SAMPLE_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
            .clk     (pixel_clk),
            .wr_en   (wr_ok && (wr_ch == 2'(k))),
            .wr_addr ({~front, wr_addr}),
            .wr_data (wr_data),
            .rd_addr ({front, col}),
            .rd_data (rd_data)
        );

        // Previous column's sample lets a step between columns be filled vertically.
        always_ff @(posedge pixel_clk) prev_q <= rd_data;

        assign sp     = s1_first ? rd_data : prev_q;
        assign rc     = sample_row(12'(Y0), 12'(rd_data), SAMPLE_W);
        assign rp     = sample_row(12'(Y0), 12'(sp), SAMPLE_W);
        assign lo     = (rc < rp) ? rc : rp;
        assign hi     = (rc < rp) ? rp : rc;
        assign hit[k] = ch_en[k] && s1_trace && ({1'b0, s1_y} >= lo) && ({1'b0, s1_y} <= hi);
    end

    always_comb begin
        pix = BLACK;
        if (s1_win) begin
            if (s1_grid) pix = DKGREEN;
            if (s1_line) pix = GREEN;
            for (int k = N_CH - 1; k >= 0; k--) begin
                if (hit[k]) pix = CH_COLOR[k];
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            front      <= 1'b0;
            pending    <= 1'b0;
            gx_q       <= '0;
            gy_q       <= '0;
            s1_win     <= 1'b0;
            s1_line    <= 1'b0;
            s1_grid    <= 1'b0;
            s1_trace   <= 1'b0;
            s1_first   <= 1'b0;
            s1_y       <= '0;
            pixel_data <= BLACK;
        end else begin
            if (frame_start) begin
                if (pending || wr_commit) front <= ~front;
                pending <= 1'b0;
            end else if (wr_commit) begin
                pending <= 1'b1;
            end
            gx_q <= (gx == GX_LAST) ? '0 : gx + 1'b1;
            if (x == X0_C) gy_q <= gy;
            s1_win     <= in_win;
            s1_line    <= on_line;
            s1_grid    <= on_grid;
            s1_trace   <= trace_col;
            s1_first   <= first_col;
            s1_y       <= y;
            pixel_data <= pix;
        end
    end

endmodule

// File: tb/tb_scope_wave_display.sv
// tb/tb_scope_wave_display.sv - directed checks of grid, traces, bank swapping and reset
module tb_scope_wave_display;

    localparam int X0 = 139;
    localparam int Y0 = 48;
    localparam logic [23:0] BLK = 24'h000000;
    localparam logic [23:0] GRN = 24'h00FF00;
    localparam logic [23:0] DKG = 24'h007F00;
    localparam logic [23:0] YEL = 24'hFFFF00;
    localparam logic [23:0] CYN = 24'h00FFFF;

    logic        pixel_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [10:0] pixel_xpos = 11'd1200;
    logic [10:0] pixel_ypos = 11'd700;
    logic [1:0]  ch_en = 2'b00;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_ch = 2'd0;
    logic [9:0]  wr_addr = 10'd0;
    logic [8:0]  wr_data = 9'd0;
    logic        wr_commit = 1'b0;
    logic        buf_busy;
    logic [23:0] pixel_data;

    logic [23:0] line_buf [0:1300];
    int n_cmp = 0;
    int n_bad = 0;

    scope_wave_display dut (
        .pixel_clk  (pixel_clk),
        .sys_rst    (sys_rst),
        .pixel_xpos (pixel_xpos),
        .pixel_ypos (pixel_ypos),
        .ch_en      (ch_en),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_commit  (wr_commit),
        .buf_busy   (buf_busy),
        .pixel_data (pixel_data)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    // Drive x=xs..xe on line y; line_buf[x] receives the pixel produced for (x,y).
    task automatic scan(input int y, input int xs, input int xe);
        pixel_ypos = 11'(y);
        for (int x = xs; x <= xe + 1; x++) begin
            pixel_xpos = 11'(x);
            tick();
            if (x - 1 >= xs) line_buf[x-1] = pixel_data;
        end
    endtask

    task automatic step_lines(input int a, input int b);
        for (int y = a; y <= b; y++) scan(y, X0, X0);
    endtask

    task automatic frame_start();
        pixel_xpos = 11'd0;
        pixel_ypos = 11'd0;
        tick();
        pixel_xpos = 11'd1200;
        pixel_ypos = 11'd700;
    endtask

    task automatic fill(input int ch, input int a0, input int a1, input int val);
        for (int a = a0; a <= a1; a++) begin
            wr_en   = 1'b1;
            wr_ch   = 2'(ch);
            wr_addr = 10'(a);
            wr_data = 9'(val);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic commit();
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_pix", pixel_data, BLK);
        chk("rst_busy", {23'd0, buf_busy}, 24'd0);
        sys_rst = 1'b0;

        // Background only
        scan(47, 490, 510);
        chk("above_win", line_buf[500], BLK);
        frame_start();
        scan(48, 138, 1141);
        chk("l48_x138", line_buf[138], BLK);
        chk("l48_x139", line_buf[139], GRN);
        chk("l48_x500", line_buf[500], GRN);
        chk("l48_x1141", line_buf[1141], BLK);
        scan(49, 138, 1141);
        chk("l49_grid203", line_buf[203], DKG);
        chk("l49_x204", line_buf[204], BLK);
        chk("l49_axis640", line_buf[640], GRN);
        chk("l49_x1140", line_buf[1140], GRN);
        step_lines(50, 95);
        scan(96, 138, 700);
        chk("l96_grid301", line_buf[301], DKG);
        chk("l96_x300", line_buf[300], BLK);
        step_lines(97, 335);
        scan(336, 138, 400);
        chk("l336_axis", line_buf[300], GRN);

        // Exact two-cycle latency
        pixel_xpos = 11'd10; pixel_ypos = 11'd10;
        repeat (3) tick();
        pixel_xpos = 11'(X0); pixel_ypos = 11'd200;
        tick();
        pixel_xpos = 11'd10; pixel_ypos = 11'd10;
        chk("lat_1", pixel_data, BLK);
        tick();
        chk("lat_2", pixel_data, GRN);
        tick();
        chk("lat_3", pixel_data, BLK);
        pixel_xpos = 11'd1200; pixel_ypos = 11'd700;

        // Bank 1 all zero, then swap it to the front
        fill(0, 0, 999, 0);
        fill(1, 0, 999, 0);
        commit();
        chk("busy_rise", {23'd0, buf_busy}, 24'd1);
        frame_start();
        chk("busy_fall", {23'd0, buf_busy}, 24'd0);

        // Constant 256 on ch0 in bank 0
        fill(0, 0, 999, 256);
        commit();
        ch_en = 2'b01;
        scan(304, 490, 510);
        chk("no_early", line_buf[500], BLK);
        frame_start();
        step_lines(48, 302);
        scan(303, 138, 510);
        chk("c256_above", line_buf[500], BLK);
        scan(304, 138, 1141);
        chk("c256_x140", line_buf[140], YEL);
        chk("c256_x640", line_buf[640], YEL);
        chk("c256_x1139", line_buf[1139], YEL);
        chk("c256_x139", line_buf[139], GRN);
        chk("c256_x1140", line_buf[1140], GRN);
        scan(305, 138, 510);
        chk("c256_below", line_buf[500], BLK);

        // Step 0 -> 511 at column 500 in bank 1
        fill(0, 0, 499, 0);
        fill(0, 500, 999, 511);
        commit();
        frame_start();
        step_lines(48, 48);
        scan(49, 138, 645);
        chk("step_y49_x639", line_buf[639], BLK);
        chk("step_y49_x640", line_buf[640], YEL);
        chk("step_y49_x641", line_buf[641], YEL);
        step_lines(50, 299);
        scan(300, 138, 645);
        chk("step_y300_x640", line_buf[640], YEL);
        chk("step_y300_x641", line_buf[641], BLK);
        step_lines(301, 559);
        scan(560, 138, 645);
        chk("step_y560_x639", line_buf[639], YEL);
        chk("step_y560_x640", line_buf[640], YEL);
        chk("step_y560_x641", line_buf[641], BLK);
        scan(561, 138, 645);
        chk("step_y561_axis", line_buf[640], GRN);
        chk("step_y561_x639", line_buf[639], BLK);

        // ch0 and ch1 both 100 in bank 0
        fill(0, 0, 999, 100);
        fill(1, 0, 999, 100);
        commit();
        frame_start();
        ch_en = 2'b11;
        step_lines(48, 459);
        scan(460, 138, 510);
        chk("both_ch0_wins", line_buf[500], YEL);
        ch_en = 2'b10;
        frame_start();
        step_lines(48, 459);
        scan(460, 138, 510);
        chk("ch1_only", line_buf[500], CYN);

        // Mid-frame commit; writes while busy are dropped
        ch_en = 2'b01;
        frame_start();
        step_lines(48, 100);
        commit();
        chk("mid_busy", {23'd0, buf_busy}, 24'd1);
        fill(0, 700, 700, 0);
        chk("busy_hold", {23'd0, buf_busy}, 24'd1);
        frame_start();
        chk("mid_swap_busy", {23'd0, buf_busy}, 24'd0);
        step_lines(48, 299);
        scan(300, 138, 845);
        chk("drop_write", line_buf[840], BLK);
        chk("bank1_shown", line_buf[640], YEL);

        // Commit coincident with frame start swaps at once
        pixel_xpos = 11'd0; pixel_ypos = 11'd0; wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
        pixel_xpos = 11'd1200; pixel_ypos = 11'd700;
        chk("fs_commit_busy", {23'd0, buf_busy}, 24'd0);
        step_lines(48, 459);
        scan(460, 138, 510);
        chk("fs_commit_swap", line_buf[500], YEL);

        // Reset mid-line with bank 1 in front and a swap pending
        commit();
        frame_start();
        commit();
        pixel_xpos = 11'(X0); pixel_ypos = 11'd460;
        repeat (3) tick();
        chk("pre_rst_pix", pixel_data, GRN);
        sys_rst = 1'b1;
        tick();
        chk("mid_rst_pix", pixel_data, BLK);
        chk("mid_rst_busy", {23'd0, buf_busy}, 24'd0);
        sys_rst = 1'b0;
        frame_start();
        step_lines(48, 459);
        scan(460, 138, 510);
        chk("bank0_after_rst", line_buf[500], YEL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
